// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared definitions for the fetch PC controller.
//   state_t          - fetch FSM states
//   DEFAULT_RESET_PC - default first fetch address
//   INSN_BYTES       - instruction size; the sequential (not-taken) PC step
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;
    localparam int          INSN_BYTES       = 4;

endpackage

// File: rtl/pc_redirect.sv
// pc_redirect: combinational redirect detector.
//   ex_resolve - a control-flow instruction resolves (already gated by caller)
//   ex_pc      - PC of the resolving instruction
//   ex_pcn     - computed next PC
//   redirect   - next PC differs from the sequential path
//   target     - word-aligned redirect target
//   misalign   - redirect whose target had nonzero low bits
module pc_redirect
    import pc_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  ex_resolve,
    input  logic [DATA_WIDTH-1:0] ex_pc,
    input  logic [DATA_WIDTH-1:0] ex_pcn,
    output logic                  redirect,
    output logic [DATA_WIDTH-1:0] target,
    output logic                  misalign
);

    assign redirect = ex_resolve && (ex_pcn != ex_pc + DATA_WIDTH'(INSN_BYTES));
    assign target   = {ex_pcn[DATA_WIDTH-1:2], 2'b00};
    assign misalign = redirect && (ex_pcn[1:0] != 2'b00);

endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch PC controller with static not-taken prediction.
//   clk, rst                          - clock, async active-high reset
//   imem_req_valid/ready/addr         - fetch request handshake (addr == pc)
//   imem_resp_valid                   - fetch data return (one outstanding)
//   if_valid, if_pc, id_ready         - instruction presented to decode
//   ex_resolve, ex_pc, ex_pcn         - control-flow resolution from execute
//   flush, misalign                   - redirect pulses
//   redirect_cnt                      - count of taken redirects
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int                    DATA_WIDTH = 64,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_resp_valid,
    output logic                  if_valid,
    output logic [DATA_WIDTH-1:0] if_pc,
    input  logic                  id_ready,
    input  logic                  ex_resolve,
    input  logic [DATA_WIDTH-1:0] ex_pc,
    input  logic [DATA_WIDTH-1:0] ex_pcn,
    output logic                  flush,
    output logic                  misalign,
    output logic [31:0]           redirect_cnt
);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] if_pc_q, if_pc_d;
    logic                  kill_q, kill_d;
    logic [31:0]           cnt_q;

    logic                  redirect;
    logic [DATA_WIDTH-1:0] target;
    logic                  req_fire;

    // Resolutions are ignored in BOOT: nothing has been fetched yet.
    pc_redirect #(.DATA_WIDTH(DATA_WIDTH)) u_redirect (
        .ex_resolve (ex_resolve && (state_q != BOOT)),
        .ex_pc      (ex_pc),
        .ex_pcn     (ex_pcn),
        .redirect   (redirect),
        .target     (target),
        .misalign   (misalign)
    );

    assign flush         = redirect;
    assign imem_req_addr = pc_q;
    assign if_pc         = if_pc_q;
    assign redirect_cnt  = cnt_q;
    assign req_fire      = imem_req_valid && imem_req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            if_pc_q <= RESET_PC;
            kill_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if_pc_q <= if_pc_d;
            kill_q  <= kill_d;
            if (redirect) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        if_pc_d        = if_pc_q;
        kill_d         = kill_q;
        if_valid       = 1'b0;
        // A killed request keeps the FSM parked in REQ without requesting.
        imem_req_valid = (state_q == REQ) && !kill_q;

        // While kill is set the only response that can arrive is the killed one.
        if (kill_q && imem_resp_valid) begin
            kill_d = 1'b0;
        end

        case (state_q)
            BOOT: state_d = REQ;
            REQ: begin
                if (req_fire) begin
                    if_pc_d = pc_q;
                    pc_d    = pc_q + DATA_WIDTH'(INSN_BYTES);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    if_valid = 1'b1;
                    state_d  = id_ready ? REQ : HOLD;
                end
            end
            HOLD: begin
                if_valid = 1'b1;
                if (id_ready) begin
                    state_d = REQ;
                end
            end
            default: state_d = BOOT;
        endcase

        // Redirect overrides everything above. A request still in flight after
        // this edge (just sent, or pending without a response this cycle) must
        // have its response dropped; a response arriving now is simply dropped.
        if (redirect) begin
            if_valid = 1'b0;
            if_pc_d  = if_pc_q;
            pc_d     = target;
            state_d  = REQ;
            if (req_fire || (state_q == WAIT && !imem_resp_valid)) begin
                kill_d = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: self-checking bench for pc_ctrl. A transaction-level model
// (in-flight / presenting / dropping flags plus pc arithmetic) predicts every
// output each cycle; directed sequences add literal expectations.
module tb_pc_ctrl;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready, imem_resp_valid;
    logic [63:0] imem_req_addr;
    logic        if_valid, id_ready, ex_resolve, flush, misalign;
    logic [63:0] if_pc, ex_pc, ex_pcn;
    logic [31:0] redirect_cnt;

    always #5 clk = ~clk;

    pc_ctrl #(.DATA_WIDTH(64), .RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .id_ready        (id_ready),
        .ex_resolve      (ex_resolve),
        .ex_pc           (ex_pc),
        .ex_pcn          (ex_pcn),
        .flush           (flush),
        .misalign        (misalign),
        .redirect_cnt    (redirect_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Model state
    bit          m_boot, m_out, m_drop, m_pres;
    logic [63:0] m_pc, m_ifpc;
    logic [31:0] m_cnt;
    // Memory responder state
    bit          mem_pend;
    int          mem_dly;
    // Reset request applied at the next driven edge
    logic        rst_drv;
    // Observed DUT values of the last step
    logic        o_req, o_ifv, o_flush, o_mis;
    logic [63:0] o_addr, o_ifpc;
    logic [31:0] o_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    task automatic model_reset();
        m_boot   = 1'b1;
        m_out    = 1'b0;
        m_drop   = 1'b0;
        m_pres   = 1'b0;
        m_pc     = RST_PC;
        m_ifpc   = RST_PC;
        m_cnt    = '0;
        mem_pend = 1'b0;
        mem_dly  = 0;
    endtask

    task automatic step(input logic rdy, input logic rsp, input logic idr,
                        input logic exr, input logic [63:0] epc, input logic [63:0] epcn);
        logic redir, e_req, e_ifv;
        @(negedge clk);
        rst             = rst_drv;
        imem_req_ready  = rdy;
        imem_resp_valid = rsp;
        id_ready        = idr;
        ex_resolve      = exr;
        ex_pc           = epc;
        ex_pcn          = epcn;
        cyc++;
        #1;
        if (rst) model_reset();
        redir = !m_boot && exr && (epcn != epc + 64'd4);
        e_req = !m_boot && !m_out && !m_pres && !m_drop;
        e_ifv = !redir && (m_pres || (m_out && rsp));
        chk("req_valid", 64'(imem_req_valid), 64'(e_req));
        chk("req_addr", imem_req_addr, m_pc);
        chk("if_valid", 64'(if_valid), 64'(e_ifv));
        chk("if_pc", if_pc, m_ifpc);
        chk("flush", 64'(flush), 64'(redir));
        chk("misalign", 64'(misalign), 64'(redir && (epcn[1:0] != 2'b00)));
        chk("redirect_cnt", 64'(redirect_cnt), 64'(m_cnt));
        o_req   = imem_req_valid;
        o_ifv   = if_valid;
        o_flush = flush;
        o_mis   = misalign;
        o_addr  = imem_req_addr;
        o_ifpc  = if_pc;
        o_cnt   = redirect_cnt;

        if (!rst) begin
            if (m_boot) begin
                m_boot = 1'b0;
            end else if (redir) begin
                // Anything still in flight after this edge is a response to drop.
                m_drop = (e_req && rdy) || (m_out && !rsp) || (m_drop && !rsp);
                m_out  = 1'b0;
                m_pres = 1'b0;
                m_pc   = epcn & ~64'd3;
                m_cnt  = m_cnt + 32'd1;
            end else begin
                if (m_drop && rsp) m_drop = 1'b0;
                if (e_req && rdy) begin
                    m_ifpc = m_pc;
                    m_pc   = m_pc + 64'd4;
                    m_out  = 1'b1;
                end else if (m_out && rsp) begin
                    m_out  = 1'b0;
                    m_pres = !idr;
                end else if (m_pres && idr) begin
                    m_pres = 1'b0;
                end
            end
            if (e_req && rdy) begin
                mem_pend = 1'b1;
                mem_dly  = int'($urandom_range(0, 2));
            end else if (rsp) begin
                mem_pend = 1'b0;
            end else if (mem_pend && mem_dly > 0) begin
                mem_dly--;
            end
        end
    endtask

    task automatic idle(input logic rdy, input logic rsp, input logic idr);
        step(rdy, rsp, idr, 1'b0, 64'd0, 64'd0);
    endtask

    initial begin
        int          hold_v, req_v;
        logic [63:0] a, epc, epcn;
        logic        exr, rsp;

        rst = 1'b1; imem_req_ready = 0; imem_resp_valid = 0; id_ready = 0;
        ex_resolve = 0; ex_pc = '0; ex_pcn = '0;
        rst_drv = 1'b1;
        model_reset();

        // Reset state
        idle(0, 0, 0);
        chk("rst_req_valid", 64'(o_req), 64'd0);
        chk("rst_addr", o_addr, 64'h8000_0000);
        chk("rst_if_pc", o_ifpc, 64'h8000_0000);
        chk("rst_cnt", 64'(o_cnt), 64'd0);
        idle(0, 0, 0);
        rst_drv = 1'b0;

        // Sequential stream: one request every two cycles
        idle(1, 0, 0);
        chk("boot_no_req", 64'(o_req), 64'd0);
        for (int k = 0; k < 3; k++) begin
            a = 64'h8000_0000 + 64'(4 * k);
            idle(1, 0, 0);
            chk("seq_req", 64'(o_req), 64'd1);
            chk("seq_addr", o_addr, a);
            idle(0, 1, 1);
            chk("seq_ifv", 64'(o_ifv), 64'd1);
            chk("seq_ifpc", o_ifpc, a);
        end

        // Decode stalls three cycles
        idle(1, 0, 0);
        hold_v = 0; req_v = 0;
        idle(0, 1, 0); hold_v += int'(o_ifv); req_v += int'(o_req); chk("hold_pc", o_ifpc, 64'h8000_000C);
        idle(0, 0, 0); hold_v += int'(o_ifv); req_v += int'(o_req); chk("hold_pc", o_ifpc, 64'h8000_000C);
        idle(0, 0, 0); hold_v += int'(o_ifv); req_v += int'(o_req); chk("hold_pc", o_ifpc, 64'h8000_000C);
        idle(0, 0, 1); hold_v += int'(o_ifv); req_v += int'(o_req); chk("hold_pc", o_ifpc, 64'h8000_000C);
        chk("hold_cycles", 64'(hold_v), 64'd4);
        chk("hold_no_req", 64'(req_v), 64'd0);
        idle(0, 0, 0);
        chk("after_hold_addr", o_addr, 64'h8000_0010);

        // Redirect in WAIT, late response dropped
        idle(1, 0, 0);
        step(0, 0, 1, 1, 64'h8000_0010, 64'h8000_0100);
        chk("redir_flush", 64'(o_flush), 64'd1);
        chk("redir_ifv", 64'(o_ifv), 64'd0);
        idle(1, 0, 0);
        chk("kill_no_req", 64'(o_req), 64'd0);
        idle(1, 1, 1);
        chk("drop_ifv", 64'(o_ifv), 64'd0);
        idle(1, 0, 0);
        chk("redir_req", 64'(o_req), 64'd1);
        chk("redir_addr", o_addr, 64'h8000_0100);
        chk("redir_cnt", 64'(o_cnt), 64'd1);
        idle(0, 1, 1);

        // Resolution on the sequential path changes nothing
        step(1, 0, 0, 1, 64'h8000_0040, 64'h8000_0044);
        chk("nt_flush", 64'(o_flush), 64'd0);
        chk("nt_addr", o_addr, 64'h8000_0104);
        step(0, 1, 1, 1, 64'h8000_0040, 64'h8000_0044);
        chk("nt_ifv", 64'(o_ifv), 64'd1);
        chk("nt_cnt", 64'(o_cnt), 64'd1);

        // Misaligned redirect target
        step(0, 0, 0, 1, 64'h8000_0050, 64'h8000_0102);
        chk("mis_pulse", 64'(o_mis), 64'd1);
        idle(1, 0, 0);
        chk("mis_addr", o_addr, 64'h8000_0100);
        chk("mis_cnt", 64'(o_cnt), 64'd2);
        idle(0, 1, 1);

        // Reset during WAIT; stale response lands in BOOT
        idle(1, 0, 0);
        rst_drv = 1'b1;
        idle(0, 0, 0);
        chk("midrst_cnt", 64'(o_cnt), 64'd0);
        rst_drv = 1'b0;
        idle(0, 1, 1);
        chk("stale_ifv", 64'(o_ifv), 64'd0);
        idle(1, 0, 0);
        chk("post_rst_addr", o_addr, 64'h8000_0000);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rsp  = mem_pend && (mem_dly == 0) && ($urandom_range(0, 3) != 0);
            exr  = ($urandom_range(0, 7) == 0);
            epc  = {$urandom, $urandom} & ~64'd3;
            case ($urandom_range(0, 3))
                0:       epcn = epc + 64'd4;
                1:       epcn = {$urandom, $urandom};
                2:       epcn = 64'hFFFF_FFFF_FFFF_FFFC;
                default: epcn = epc;
            endcase
            step(1'($urandom_range(0, 1)), rsp, 1'($urandom_range(0, 1)), exr, epc, epcn);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, the PC/address width.
REQ-002 SHALL have parameter RESET_PC, default 64'h8000_0000, the first fetch address.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-006 SHALL have port imem_req_ready  input  1  the memory accepts the request this cycle.
REQ-007 SHALL have port imem_req_addr  output  DATA_WIDTH  fetch address, always equal to pc.
REQ-008 SHALL have port imem_resp_valid  input  1  fetch data returns; at most one request is outstanding.
REQ-009 SHALL have port if_valid  output  1  the fetched instruction for if_pc is presented to decode.
REQ-010 SHALL have port if_pc  output  DATA_WIDTH  PC of the presented instruction.
REQ-011 SHALL have port id_ready  input  1  decode consumes the presented instruction.
REQ-012 SHALL have port ex_resolve  input  1  a control-flow instruction resolves in execute this cycle.
REQ-013 SHALL have port ex_pc  input  DATA_WIDTH  PC of the resolving instruction.
REQ-014 SHALL have port ex_pcn  input  DATA_WIDTH  next PC computed by the branch/jump next-PC unit.
REQ-015 SHALL have port flush  output  1  one-cycle pulse that kills younger instructions in IF/ID.
REQ-016 SHALL have port misalign  output  1  one-cycle pulse when a redirect target has ex_pcn[1:0] != 0.
REQ-017 SHALL have port redirect_cnt  output  32  count of taken redirects (performance counter).

Function
REQ-018 SHALL implement the FSM states BOOT, REQ, WAIT and HOLD.
REQ-019 SHALL follow the static not-taken policy: after each accepted request, pc advances to pc+4, modulo 2^DATA_WIDTH.
REQ-020 BOOT SHALL last exactly one cycle after reset deassertion, then go to REQ; imem_req_valid=0 in BOOT.
REQ-021 REQ SHALL assert imem_req_valid; on imem_req_ready=1 it SHALL latch if_pc<=pc, set pc<=pc+4 and go to WAIT.
REQ-022 WAIT SHALL hold imem_req_valid=0; on imem_resp_valid=1 it SHALL assert if_valid in the same cycle.
REQ-023 In WAIT, if id_ready=1 in the response cycle, the FSM SHALL go to REQ; otherwise it SHALL go to HOLD.
REQ-024 HOLD SHALL keep if_valid=1 and if_pc stable until id_ready=1, then go to REQ.
REQ-025 A redirect SHALL occur when ex_resolve=1 and ex_pcn != ex_pc+4.
REQ-026 On a redirect, the block SHALL pulse flush for that cycle, load pc<=ex_pcn and increment redirect_cnt (wrap at 2^32).
REQ-027 On a redirect, the FSM SHALL go to REQ, from any non-BOOT state, on the next edge.
REQ-028 A redirect in REQ with imem_req_ready=1 SHALL still send the request to the memory, but the response SHALL be dropped via the kill flag.
REQ-029 A redirect in WAIT SHALL set a kill flag; the pending response SHALL be dropped (if_valid=0) and the kill flag cleared when it returns.
REQ-030 While the kill flag is set, the FSM SHALL NOT issue a new request: it waits in REQ with imem_req_valid=0.
REQ-031 If the dropped response arrives in the same cycle as the redirect, it SHALL be dropped and the kill flag SHALL NOT be set.
REQ-032 If ex_pcn[1:0] != 0 on a redirect, the block SHALL also pulse misalign, and pc SHALL be {ex_pcn[DATA_WIDTH-1:2],2'b00}.
REQ-033 if_valid SHALL be forced to 0 in any cycle where flush=1.
REQ-034 A redirect SHALL take priority over id_ready and imem_resp_valid in the same cycle.

Reset
REQ-035 While rst=1, the block SHALL set: state=BOOT, pc=RESET_PC, if_pc=RESET_PC, kill flag=0, redirect_cnt=0.
REQ-036 While rst=1, all outputs SHALL be 0 except imem_req_addr and if_pc, which SHALL equal RESET_PC.
REQ-037 Reset asserted mid-WAIT SHALL discard the outstanding request; any response arriving in BOOT SHALL be ignored.

Structure
REQ-038 A shared package SHALL hold the FSM state enum, the default RESET_PC, and the instruction-size constant 4.
REQ-039 The redirect detector (compare, target alignment, misalign) SHALL be one combinational sub-module, pc_redirect.

Verification
REQ-040 Reset release, req_ready=1 and resp the next cycle, id_ready=1 -> requests at 0x8000_0000, 0x8000_0004 and 0x8000_0008, one per 2 cycles.
REQ-041 Response arrives with id_ready=0 for 3 cycles -> if_valid is held 4 cycles with if_pc stable; no new request until consumed.
REQ-042 In WAIT, ex_resolve with ex_pc=0x8000_0010 and ex_pcn=0x8000_0100 -> flush pulse; the late response is dropped; the next request is 0x8000_0100; redirect_cnt=1.
REQ-043 ex_resolve with ex_pcn=ex_pc+4 -> no flush, no counter change, fetch stream undisturbed.
REQ-044 Redirect to 0x8000_0102 -> misalign pulse and the next request is 0x8000_0100.
REQ-045 rst asserted during WAIT with a response one cycle after release -> if_valid stays 0; the first request is RESET_PC.
